// File: rtl/rand_byte_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rand_byte_buffer                                                 |
// | Brief   : Edge-captured PRNG byte sink with repetition health test and FWFT |
// |           FIFO, drained by an out_valid/out_ready handshake.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rand_byte_buffer #(
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         byte_cnt,
  output logic                     overflow,
  output logic                     health_err,
  input  logic                     clear_err
);

  localparam int                 c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W + 1)'(1);
  localparam logic [3:0]         c_REP_LIMIT = 4'(REP_LIMIT);
  localparam logic [3:0]         c_RUN_MAX   = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_valid_d;
  logic [3:0]           r_run;
  logic                 r_have_last;
  logic [7:0]           r_last;
  logic                 r_overflow;
  logic                 r_health_err;
  logic [7:0]           r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic [CNT_W-1:0]     r_byte_cnt;

  logic                 w_out_valid;
  logic                 w_cap;
  logic                 w_cap_run;
  logic                 w_repeat;
  logic [3:0]           w_run_next;
  logic                 w_fail;
  logic                 w_pop;
  logic                 w_has_room;
  logic                 w_push;
  logic                 w_drop;

  assign w_out_valid = (r_count != '0) && (r_state == ST_RUN);

  always_comb begin
    w_cap      = in_valid & ~r_valid_d;
    // clear_err wins over a simultaneous capture; FAULT ignores captures
    w_cap_run  = w_cap & (r_state == ST_RUN) & ~clear_err;
    w_repeat   = r_have_last & (in_data == r_last);
    w_run_next = 4'd1;
    if (w_repeat) begin
      w_run_next = (r_run == c_RUN_MAX) ? c_RUN_MAX : r_run + 4'd1;
    end
    w_fail     = w_cap_run & (w_run_next == c_REP_LIMIT);
    w_pop      = w_out_valid & out_ready & ~w_fail;
    // a full FIFO still accepts when the head leaves on the same edge
    w_has_room = (r_count != c_DEPTH) | w_pop;
    w_push     = w_cap_run & ~w_fail & w_has_room;
    w_drop     = w_cap_run & ~w_fail & ~w_has_room;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= ST_RUN;
      r_valid_d    <= 1'b0;
      r_run        <= 4'd0;
      r_have_last  <= 1'b0;
      r_last       <= 8'h00;
      r_overflow   <= 1'b0;
      r_health_err <= 1'b0;
    end else begin
      r_valid_d <= in_valid;
      if (clear_err) begin
        r_state      <= ST_RUN;
        r_run        <= 4'd0;
        r_have_last  <= 1'b0;
        r_last       <= 8'h00;
        r_overflow   <= 1'b0;
        r_health_err <= 1'b0;
      end else if (w_cap_run) begin
        r_run       <= w_run_next;
        r_last      <= in_data;
        r_have_last <= 1'b1;
        if (w_fail) begin
          r_state      <= ST_FAULT;
          r_health_err <= 1'b1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_cnt <= '0;
    end else if (w_fail) begin
      // flush: read pointer catches up, any pop this cycle is void
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_valid  = w_out_valid;
  assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count = r_count;
  assign byte_cnt   = r_byte_cnt;
  assign overflow   = r_overflow;
  assign health_err = r_health_err;

endmodule
`default_nettype wire
